// File: rtl/mult_ctrl_unit.sv
// rtl/mult_ctrl_unit.sv - control FSM for the signed add-shift multiplier
module mult_ctrl_unit #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_B,
    output logic Ld_A,
    output logic Ld_X,
    output logic Shift_En,
    output logic Fn,
    output logic Busy,
    output logic Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    // The final iteration is the sign-bit iteration: it subtracts and ends the loop.
    assign w_last = (r_cnt == LAST);

    // State and iteration counter; reset drops straight back to IDLE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Run) begin
                        r_state <= S_CLR;
                        r_cnt   <= '0;
                    end
                end
                S_CLR:   r_state <= S_ADD;
                S_ADD:   r_state <= S_SHIFT;
                S_SHIFT: begin
                    if (w_last) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_ADD;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    // Stay until the button is released: one multiply per press.
                    if (!Run) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        Clr_XA   = 1'b0;
        Ld_B     = 1'b0;
        Ld_A     = 1'b0;
        Ld_X     = 1'b0;
        Shift_En = 1'b0;
        Fn       = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (Reset) begin
            case (r_state)
                S_CLR: begin
                    Clr_XA = 1'b1;
                    Busy   = 1'b1;
                end
                S_ADD: begin
                    Busy = 1'b1;
                    Ld_A = M;
                    Ld_X = M;
                    Fn   = w_last;
                end
                S_SHIFT: begin
                    Busy     = 1'b1;
                    Shift_En = 1'b1;
                end
                S_HOLD: begin
                    Done = 1'b1;
                end
                default: begin
                    // IDLE and any illegal encoding; a pending start wins over clear/load.
                    if (!Run && ClearA_LoadB) begin
                        Clr_XA = 1'b1;
                        Ld_B   = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl_unit.sv
// tb/tb_mult_ctrl_unit.sv - directed self-checking bench for mult_ctrl_unit
module tb_mult_ctrl_unit;

    logic Clk;
    logic Reset;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_XA, Ld_B, Ld_A, Ld_X, Shift_En, Fn, Busy, Done;
    logic [7:0] outs;

    int n_checks = 0;
    int n_err    = 0;

    mult_ctrl_unit #(.N(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_XA       (Clr_XA),
        .Ld_B         (Ld_B),
        .Ld_A         (Ld_A),
        .Ld_X         (Ld_X),
        .Shift_En     (Shift_En),
        .Fn           (Fn),
        .Busy         (Busy),
        .Done         (Done)
    );

    // {Clr_XA, Ld_B, Ld_A, Ld_X, Shift_En, Fn, Busy, Done}
    assign outs = {Clr_XA, Ld_B, Ld_A, Ld_X, Shift_En, Fn, Busy, Done};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One full multiply; every step begins just after a negedge.
    task automatic do_mult(input logic m, input logic hold, input string tag);
        int n_busy;
        int n_lda;
        int n_ldx;
        int n_sh;
        int n_fn;
        logic [7:0] e;
        n_busy = 0;
        n_lda  = 0;
        n_ldx  = 0;
        n_sh   = 0;
        n_fn   = 0;
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        M = m;
        #1;
        chk({tag, "_start_prio"}, outs, 8'b0000_0000);
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge Clk);
            ClearA_LoadB = cyc[0];
            Run = hold;
            M = (cyc % 2 == 0) ? m : ~m;
            #1;
            if (cyc == 1)
                e = 8'b1000_0010;
            else if (cyc % 2 == 0)
                e = {2'b00, m, m, 1'b0, (cyc == 16), 1'b1, 1'b0};
            else
                e = 8'b0000_1010;
            chk($sformatf("%s_cyc%0d", tag, cyc), outs, e);
            n_busy += int'(Busy);
            n_lda  += int'(Ld_A);
            n_ldx  += int'(Ld_X);
            n_sh   += int'(Shift_En);
            n_fn   += int'(Fn);
        end
        chk({tag, "_busy_cnt"}, 8'(n_busy), 8'd17);
        chk({tag, "_lda_cnt"}, 8'(n_lda), m ? 8'd8 : 8'd0);
        chk({tag, "_ldx_cnt"}, 8'(n_ldx), m ? 8'd8 : 8'd0);
        chk({tag, "_shift_cnt"}, 8'(n_sh), 8'd8);
        chk({tag, "_fn_cnt"}, 8'(n_fn), 8'd1);
        @(negedge Clk);
        ClearA_LoadB = 1'b1;
        Run = hold;
        #1;
        chk({tag, "_done"}, outs, 8'b0000_0001);
        if (hold) begin
            for (int h = 0; h < 2; h++) begin
                @(negedge Clk);
                #1;
                chk($sformatf("%s_hold%0d", tag, h), outs, 8'b0000_0001);
            end
        end
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        #1;
        chk({tag, "_back_idle"}, outs, 8'b0000_0000);
    endtask

    initial begin
        Reset = 1'b0;
        Run = 1'b0;
        ClearA_LoadB = 1'b1;
        M = 1'b1;
        #1;
        chk("reset_outs", outs, 8'b0000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            #1;
            chk($sformatf("reset_hold%0d", i), outs, 8'b0000_0000);
        end
        ClearA_LoadB = 1'b0;
        Reset = 1'b1;
        #1;
        chk("reset_release_idle", outs, 8'b0000_0000);
        @(negedge Clk);
        #1;
        chk("idle_quiet", outs, 8'b0000_0000);

        ClearA_LoadB = 1'b1;
        #1;
        chk("idle_clear_load", outs, 8'b1100_0000);
        Reset = 1'b0;
        #1;
        chk("async_reset_midcycle", outs, 8'b0000_0000);
        Reset = 1'b1;
        #1;
        chk("after_async_release", outs, 8'b1100_0000);
        @(negedge Clk);

        do_mult(1'b1, 1'b1, "m1_hold");
        do_mult(1'b1, 1'b0, "m1_again");
        do_mult(1'b0, 1'b0, "m0");

        ClearA_LoadB = 1'b0;
        Run = 1'b1;
        M = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge Clk);
            Run = 1'b0;
        end
        #1;
        chk("abort_third_shift", outs, 8'b0000_1010);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_reset_immediate", outs, 8'b0000_0000);
        @(negedge Clk);
        #1;
        chk("abort_reset_held", outs, 8'b0000_0000);
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        chk("abort_idle_no_restart", outs, 8'b0000_0000);

        do_mult(1'b1, 1'b0, "post_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_ctrl_unit.md
Name: mult_ctrl_unit

Overview:
Control FSM for the 8-bit add-shift multiplier. It drives the load, clear and shift enables of the A/B shift registers and the X sign flip-flop, and selects add or subtract on the 9-bit adder. It sits directly upstream of the register unit and consumes the multiplier LSB (B register Shift_Out) as its decision input. Implements signed (two's-complement) multiply: add on iterations 0..N-2, subtract on iteration N-1.

Parameters:
N, 8, number of multiplier bits / add-shift iterations (N >= 2)
CW, $clog2(N), iteration counter width

Ports:
Clk  in  1  system clock, all state changes on posedge
Reset  in  1  asynchronous, active-low reset; Reset=0 forces IDLE immediately, independent of Clk
Run  in  1  synchronous level from debounced button; 1 = start / hold
ClearA_LoadB  in  1  synchronous level; 1 in IDLE = clear A and X, load B from switches
M  in  1  current multiplier LSB (B register bit 0)
Clr_XA  out  1  synchronous clear to A register and X flip-flop
Ld_B  out  1  load B register from switches
Ld_A  out  1  load A register with adder result bits [7:0]
Ld_X  out  1  load X flip-flop with adder result bit 8
Shift_En  out  1  shift A and B right one position (X -> A MSB, A LSB -> B MSB)
Fn  out  1  adder function: 0 = A + S, 1 = A - S
Busy  out  1  multiplication in progress
Done  out  1  result valid in {X, A, B}

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, HOLD; iteration counter cnt (CW bits).
- Reset=0 (async): state=IDLE, cnt=0. All outputs are combinational decodes of state/cnt/inputs, so during reset: every output = 0.
- IDLE: Busy=0, Done=0. Run=1 sampled at posedge -> CLR, cnt<=0. Otherwise stay.
- IDLE, Run=0, ClearA_LoadB=1: Clr_XA=1, Ld_B=1 (combinational, same cycle). Run=1 has priority: Clr_XA/Ld_B=0 on that cycle.
- CLR (1 cycle): Clr_XA=1, Busy=1 -> ADD.
- ADD (1 cycle): Busy=1; Ld_A=Ld_X=M; Fn=1 iff cnt==N-1, else 0. When M=0: Ld_A=Ld_X=0 and Fn still reflects cnt. -> SHIFT.
- SHIFT (1 cycle): Busy=1, Shift_En=1. If cnt==N-1 -> HOLD, cnt<=0; else cnt<=cnt+1, -> ADD.
- HOLD: Done=1, Busy=0; all enables 0. Run=0 -> IDLE; Run=1 -> stay (one multiply per button press).
- Latency: Run sampled at edge k -> Busy high cycles k+1 .. k+2N+1 (2N+1 = 17 cycles for N=8) -> Done high from cycle k+2N+2.
- Exactly N Shift_En pulses and at most N Ld_A pulses per multiply. Fn=1 appears only in the ADD state with cnt==N-1.
- ClearA_LoadB and Run changes are ignored outside IDLE/HOLD. ClearA_LoadB in HOLD has no effect.
- M is sampled only in ADD. M changes in other states have no effect.
- Reset mid-operation (any state): immediate IDLE, cnt=0, all outputs 0. The next multiply requires a fresh Run=1 after reset release.
- Mutual exclusion (assertable): Shift_En is never high together with Ld_A, Clr_XA or Ld_B. Ld_A==Ld_X always.
- Counter never wraps: cnt in [0, N-1]. Out-of-range states decode to IDLE.

Test Plan:
- Reset=0 for 3 cycles, then release -> all outputs 0, state IDLE. Assert Reset=0 asynchronously mid-cycle -> outputs drop before the next posedge.
- IDLE, ClearA_LoadB=1, Run=0 -> Clr_XA=1, Ld_B=1 same cycle. Add Run=1 -> Clr_XA/Ld_B=0 at ClearA_LoadB, then CLR next cycle.
- Run pulse with M held 1 -> exactly 17 Busy cycles, 8 Ld_A/Ld_X pulses, 8 Shift_En pulses, Fn=1 only on the 8th ADD. Then Done=1. With the full datapath: B=8'hFF (-1), S=8'h07 -> {A,B}=16'hFFF9 (-7).
- M held 0 -> 8 Shift_En pulses, zero Ld_A/Ld_X pulses, Done after 17 cycles. With the datapath: S=8'h80, B=8'h00 -> {A,B}=0.
- Run held high through completion -> stays in HOLD with Done=1 and no extra enables. Drop Run -> IDLE. Raise Run again -> a second full multiply.
- Reset=0 during the 3rd SHIFT -> immediate IDLE, cnt=0. Toggle ClearA_LoadB while Busy=1 -> no Clr_XA/Ld_B.
